// File: rtl/ball_pkg.sv
// Shared definitions for the ball game sequencer: state encoding, motion constants,
// and default play-field geometry.
package ball_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_CHECK = 3'd3,
        ST_MOVE  = 3'd4,
        ST_MISS  = 3'd5,
        ST_OVER  = 3'd6
    } state_e;

    localparam int BALL_STEP = 2;
    localparam int HOME_H    = 200;
    localparam int HOME_V    = 300;

    localparam int H_MIN_DEF        = 8;
    localparam int V_MIN_DEF        = 8;
    localparam int V_MAX_DEF        = 472;
    localparam int PADDLE_H_DEF     = 600;
    localparam int PADDLE_LEN_DEF   = 64;
    localparam int LIVES_INIT_DEF   = 3;
    localparam int SERVE_FRAMES_DEF = 60;

    localparam int POS_W       = 11;
    localparam int SCORE_W     = 8;
    localparam int SERVE_CNT_W = 8;

    // Score counter stops at its maximum instead of wrapping.
    function automatic logic [SCORE_W-1:0] sat_inc_score(input logic [SCORE_W-1:0] s);
        return (s == {SCORE_W{1'b1}}) ? s : s + 1'b1;
    endfunction

endpackage

// File: rtl/ball_collide.sv
// Combinational wall/paddle test for one ball step: returns the next direction bits,
// a paddle hit flag and a miss flag (ball reached the paddle column off the paddle).
module ball_collide
    import ball_pkg::*;
#(
    parameter int H_MIN      = H_MIN_DEF,
    parameter int V_MIN      = V_MIN_DEF,
    parameter int V_MAX      = V_MAX_DEF,
    parameter int PADDLE_H   = PADDLE_H_DEF,
    parameter int PADDLE_LEN = PADDLE_LEN_DEF
)
(
    input  logic [POS_W-1:0] h_pos_i,
    input  logic [POS_W-1:0] v_pos_i,
    input  logic [POS_W-1:0] paddle_v_i,
    input  logic             dh_i,
    input  logic             dv_i,
    output logic             dh_o,
    output logic             dv_o,
    output logic             hit_o,
    output logic             miss_o
);

    // One extra bit so position + step and paddle + length cannot wrap.
    logic [POS_W:0] h_ext;
    logic [POS_W:0] v_ext;
    logic [POS_W:0] pv_top;
    logic [POS_W:0] pv_bot;
    logic           on_paddle;

    assign h_ext     = {1'b0, h_pos_i};
    assign v_ext     = {1'b0, v_pos_i};
    assign pv_top    = {1'b0, paddle_v_i};
    assign pv_bot    = pv_top + (POS_W+1)'(PADDLE_LEN);
    assign on_paddle = (v_ext >= pv_top) && (v_ext <= pv_bot);

    always_comb begin
        dh_o   = dh_i;
        dv_o   = dv_i;
        hit_o  = 1'b0;
        miss_o = 1'b0;

        if (!dh_i && (h_ext < (POS_W+1)'(H_MIN + BALL_STEP))) begin
            dh_o = 1'b1;
        end
        if (dh_i && ((h_ext + (POS_W+1)'(BALL_STEP)) >= (POS_W+1)'(PADDLE_H))) begin
            if (on_paddle) begin
                dh_o  = 1'b0;
                hit_o = 1'b1;
            end else begin
                miss_o = 1'b1;
            end
        end

        if (!dv_i && (v_ext < (POS_W+1)'(V_MIN + BALL_STEP))) begin
            dv_o = 1'b1;
        end
        if (dv_i && ((v_ext + (POS_W+1)'(BALL_STEP)) > (POS_W+1)'(V_MAX))) begin
            dv_o = 1'b0;
        end
    end

endmodule

// File: rtl/ball_ctrl.sv
// Ball game sequencer: serve/play/miss/game-over flow, score and lives, one move per frame.
// Optional BALL_SPEEDUP_EN: up to four CHECK/MOVE pairs per frame as the score grows.
module ball_ctrl
    import ball_pkg::*;
#(
    parameter int H_MIN        = H_MIN_DEF,
    parameter int V_MIN        = V_MIN_DEF,
    parameter int V_MAX        = V_MAX_DEF,
    parameter int PADDLE_H     = PADDLE_H_DEF,
    parameter int PADDLE_LEN   = PADDLE_LEN_DEF,
    parameter int LIVES_INIT   = LIVES_INIT_DEF,
    parameter int SERVE_FRAMES = SERVE_FRAMES_DEF
)
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               pause_btn,
    input  logic               frame_tick,
    input  logic [POS_W-1:0]   h_pos,
    input  logic [POS_W-1:0]   v_pos,
    input  logic [POS_W-1:0]   paddle_v,
    output logic               dh,
    output logic               dv,
    output logic               ball_pause,
    output logic               ball_rst,
    output logic [SCORE_W-1:0] score,
    output logic [1:0]         lives,
    output logic [2:0]         state,
    output logic               game_over
);

    state_e                 state_q;
    logic                   dh_q;
    logic                   dv_q;
    logic                   pause_q;
    logic                   brst_q;
    logic [SCORE_W-1:0]     score_q;
    logic [1:0]             lives_q;
    logic [SERVE_CNT_W-1:0] serve_cnt_q;
    logic                   over_q;

    logic                   dh_n;
    logic                   dv_n;
    logic                   hit;
    logic                   miss;
    logic [SCORE_W-1:0]     score_d;
    logic [1:0]             lives_d;
    logic                   more_moves;

    ball_collide #(
        .H_MIN      (H_MIN),
        .V_MIN      (V_MIN),
        .V_MAX      (V_MAX),
        .PADDLE_H   (PADDLE_H),
        .PADDLE_LEN (PADDLE_LEN)
    ) u_collide (
        .h_pos_i    (h_pos),
        .v_pos_i    (v_pos),
        .paddle_v_i (paddle_v),
        .dh_i       (dh_q),
        .dv_i       (dv_q),
        .dh_o       (dh_n),
        .dv_o       (dv_n),
        .hit_o      (hit),
        .miss_o     (miss)
    );

    assign score_d = sat_inc_score(score_q);
    assign lives_d = lives_q - 2'd1;

`ifdef BALL_SPEEDUP_EN
    logic [1:0] mv_q;
    logic [1:0] mv_last;

    // Extra moves per frame = min(score/8, 3); score only grows, so mv_last never drops.
    assign mv_last    = (score_q[SCORE_W-1:3] > 5'd3) ? 2'd3 : score_q[4:3];
    assign more_moves = (mv_q < mv_last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mv_q <= 2'd0;
        end else if (state_q == ST_WAIT) begin
            mv_q <= 2'd0;
        end else if ((state_q == ST_MOVE) && more_moves) begin
            mv_q <= mv_q + 2'd1;
        end
    end
`else
    assign more_moves = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            dh_q        <= 1'b1;
            dv_q        <= 1'b0;
            pause_q     <= 1'b1;
            brst_q      <= 1'b1;
            score_q     <= '0;
            lives_q     <= 2'(LIVES_INIT);
            serve_cnt_q <= '0;
            over_q      <= 1'b0;
        end else begin
            // ball_pause is low only for the single cycle spent in MOVE.
            pause_q <= 1'b1;
            case (state_q)
                ST_IDLE, ST_OVER: begin
                    if (start) begin
                        state_q     <= ST_SERVE;
                        score_q     <= '0;
                        lives_q     <= 2'(LIVES_INIT);
                        serve_cnt_q <= '0;
                        dh_q        <= 1'b1;
                        dv_q        <= 1'b0;
                        brst_q      <= 1'b1;
                        over_q      <= 1'b0;
                    end
                end
                ST_SERVE: begin
                    brst_q <= 1'b1;
                    dh_q   <= 1'b1;
                    dv_q   <= 1'b0;
                    if (frame_tick) begin
                        if (serve_cnt_q == SERVE_CNT_W'(SERVE_FRAMES - 1)) begin
                            serve_cnt_q <= '0;
                            brst_q      <= 1'b0;
                            state_q     <= ST_WAIT;
                        end else begin
                            serve_cnt_q <= serve_cnt_q + 1'b1;
                        end
                    end
                end
                ST_WAIT: begin
                    if (frame_tick && !pause_btn) begin
                        state_q <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (miss) begin
                        state_q <= ST_MISS;
                    end else begin
                        dh_q    <= dh_n;
                        dv_q    <= dv_n;
                        pause_q <= 1'b0;
                        state_q <= ST_MOVE;
                        if (hit) begin
                            score_q <= score_d;
                        end
                    end
                end
                ST_MOVE: begin
                    state_q <= more_moves ? ST_CHECK : ST_WAIT;
                end
                ST_MISS: begin
                    lives_q <= lives_d;
                    brst_q  <= 1'b1;
                    if (lives_d == 2'd0) begin
                        state_q <= ST_OVER;
                        over_q  <= 1'b1;
                    end else begin
                        state_q     <= ST_SERVE;
                        serve_cnt_q <= '0;
                        dh_q        <= 1'b1;
                        dv_q        <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign dh         = dh_q;
    assign dv         = dv_q;
    assign ball_pause = pause_q;
    assign ball_rst   = brst_q;
    assign score      = score_q;
    assign lives      = lives_q;
    assign state      = state_q;
    assign game_over  = over_q;

endmodule

// File: tb/tb_ball_ctrl.sv
// Self-checking bench for ball_ctrl: expected per-frame results are queued at stimulus
// time and popped when the frame's move window has elapsed.
module tb_ball_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        pause_btn;
    logic        frame_tick;
    logic [10:0] h_pos;
    logic [10:0] v_pos;
    logic [10:0] paddle_v;
    logic        dh;
    logic        dv;
    logic        ball_pause;
    logic        ball_rst;
    logic [7:0]  score;
    logic [1:0]  lives;
    logic [2:0]  state;
    logic        game_over;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic       dh;
        logic       dv;
        logic [7:0] score;
        logic [1:0] lives;
        logic [2:0] st;
        int         pulses;
    } exp_t;

    exp_t sbq[$];

    ball_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .pause_btn  (pause_btn),
        .frame_tick (frame_tick),
        .h_pos      (h_pos),
        .v_pos      (v_pos),
        .paddle_v   (paddle_v),
        .dh         (dh),
        .dv         (dv),
        .ball_pause (ball_pause),
        .ball_rst   (ball_rst),
        .score      (score),
        .lives      (lives),
        .state      (state),
        .game_over  (game_over)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion earlier");
        $fatal(1, "watchdog");
    end

    // Drives one frame_tick with the given position, then watches 6 clks for move pulses.
    task automatic run_frame(input logic [10:0] h, input logic [10:0] v, input logic [10:0] pv,
                             output int npulse, output int first_cyc);
        h_pos      = h;
        v_pos      = v;
        paddle_v   = pv;
        frame_tick = 1'b1;
        npulse     = 0;
        first_cyc  = -1;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk); #1;
            frame_tick = 1'b0;
            if (ball_pause === 1'b0) begin
                npulse++;
                if (first_cyc < 0) first_cyc = c;
            end
        end
    endtask

    task automatic serve_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1;
            @(posedge clk); #1;
            frame_tick = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; pause_btn = 1'b0; frame_tick = 1'b0;
        h_pos = 11'd200; v_pos = 11'd300; paddle_v = 11'd0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({state, dh, dv, ball_pause, ball_rst, score, lives, game_over} !==
            {3'd0, 1'b1, 1'b0, 1'b1, 1'b1, 8'd0, 2'd3, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_in: state=%0d dh=%0b dv=%0b bp=%0b brst=%0b score=%0d lives=%0d go=%0b, required 0 1 0 1 1 0 3 0",
                     state, dh, dv, ball_pause, ball_rst, score, lives, game_over);
        end
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({state, ball_pause, ball_rst} !== {3'd0, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_idle: state=%0d bp=%0b brst=%0b, required 0 1 1", state, ball_pause, ball_rst);
        end
    endtask

    task automatic test_serve();
        pulse_start();
        n_checks++;
        if (state !== 3'd1) begin
            n_fail++;
            $display("FAIL serve_entry: state=%0d, required 1", state);
        end
        serve_ticks(59);
        n_checks++;
        if ({state, ball_rst} !== {3'd1, 1'b1}) begin
            n_fail++;
            $display("FAIL serve_59: state=%0d brst=%0b, required 1 1", state, ball_rst);
        end
        serve_ticks(1);
        n_checks++;
        if ({state, ball_rst, dh, dv, lives, score} !== {3'd2, 1'b0, 1'b1, 1'b0, 2'd3, 8'd0}) begin
            n_fail++;
            $display("FAIL serve_60: state=%0d brst=%0b dh=%0b dv=%0b lives=%0d score=%0d, required 2 0 1 0 3 0",
                     state, ball_rst, dh, dv, lives, score);
        end
    endtask

    task automatic test_play();
        // h, v, paddle_v, dh, dv, score, lives, state, pulses
        int tbl[7][9] = '{
            '{300, 300,   0, 1, 0, 0, 3, 2, 1},
            '{599, 300, 280, 0, 0, 1, 3, 2, 1},
            '{  6,   9,   0, 1, 1, 1, 3, 2, 1},
            '{300, 471,   0, 1, 0, 1, 3, 2, 1},
            '{598, 344, 280, 0, 0, 2, 3, 2, 1},
            '{  8, 300,   0, 1, 0, 2, 3, 2, 1},
            '{597, 300, 400, 1, 0, 2, 3, 2, 1}
        };
        int   np;
        int   fc;
        exp_t e;
        for (int i = 0; i < 7; i++) begin
            sbq.push_back('{dh: tbl[i][3][0], dv: tbl[i][4][0], score: 8'(tbl[i][5]),
                            lives: 2'(tbl[i][6]), st: 3'(tbl[i][7]), pulses: tbl[i][8]});
            run_frame(11'(tbl[i][0]), 11'(tbl[i][1]), 11'(tbl[i][2]), np, fc);
            e = sbq.pop_front();
            n_checks++;
            if ({dh, dv, score, lives, state} !== {e.dh, e.dv, e.score, e.lives, e.st}) begin
                n_fail++;
                $display("FAIL play_%0d: dh=%0b dv=%0b score=%0d lives=%0d state=%0d, required %0b %0b %0d %0d %0d",
                         i, dh, dv, score, lives, state, e.dh, e.dv, e.score, e.lives, e.st);
            end
            n_checks++;
            if (np !== e.pulses) begin
                n_fail++;
                $display("FAIL play_pulses_%0d: pulses=%0d, required %0d", i, np, e.pulses);
            end
            if (e.pulses == 1) begin
                n_checks++;
                if (fc !== 2) begin
                    n_fail++;
                    $display("FAIL play_latency_%0d: pulse at clk %0d after tick, required 2", i, fc);
                end
            end
        end
    endtask

    task automatic test_miss_over();
        // h, v, paddle_v, dh, dv, score, lives, state
        int   tbl[3][8] = '{
            '{599, 279, 280, 1, 0, 2, 2, 1},
            '{599, 400,   0, 1, 0, 2, 1, 1},
            '{600, 100, 200, 1, 0, 2, 0, 6}
        };
        int   np;
        int   fc;
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            sbq.push_back('{dh: tbl[i][3][0], dv: tbl[i][4][0], score: 8'(tbl[i][5]),
                            lives: 2'(tbl[i][6]), st: 3'(tbl[i][7]), pulses: 0});
            run_frame(11'(tbl[i][0]), 11'(tbl[i][1]), 11'(tbl[i][2]), np, fc);
            e = sbq.pop_front();
            n_checks++;
            if ({dh, dv, score, lives, state, ball_rst} !== {e.dh, e.dv, e.score, e.lives, e.st, 1'b1}) begin
                n_fail++;
                $display("FAIL miss_%0d: dh=%0b dv=%0b score=%0d lives=%0d state=%0d brst=%0b, required %0b %0b %0d %0d %0d 1",
                         i, dh, dv, score, lives, state, ball_rst, e.dh, e.dv, e.score, e.lives, e.st);
            end
            n_checks++;
            if (np !== 0) begin
                n_fail++;
                $display("FAIL miss_pulses_%0d: pulses=%0d, required 0", i, np);
            end
            if (e.st == 3'd1) serve_ticks(60);
        end
        n_checks++;
        if (game_over !== 1'b1) begin
            n_fail++;
            $display("FAIL over_flag: game_over=%0b, required 1", game_over);
        end
        pulse_start();
        n_checks++;
        if ({state, lives, score, game_over} !== {3'd1, 2'd3, 8'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL restart: state=%0d lives=%0d score=%0d go=%0b, required 1 3 0 0",
                     state, lives, score, game_over);
        end
        serve_ticks(60);
    endtask

    task automatic test_pause();
        int np;
        int fc;
        int total = 0;
        pause_btn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            run_frame(11'd300, 11'd300, 11'd0, np, fc);
            total += np;
        end
        n_checks++;
        if ({total, state} !== {32'd0, 3'd2}) begin
            n_fail++;
            $display("FAIL pause: pulses=%0d state=%0d, required 0 2", total, state);
        end
        pause_btn = 1'b0;
        pulse_start();
        n_checks++;
        if ({state, score, lives} !== {3'd2, 8'd0, 2'd3}) begin
            n_fail++;
            $display("FAIL start_ignored: state=%0d score=%0d lives=%0d, required 2 0 3", state, score, lives);
        end
    endtask

    task automatic test_rst_in_move();
        int np = 0;
        h_pos = 11'd300; v_pos = 11'd300; paddle_v = 11'd0;
        frame_tick = 1'b1;
        @(posedge clk); #1;
        frame_tick = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if ({state, ball_pause} !== {3'd4, 1'b0}) begin
            n_fail++;
            $display("FAIL move_reached: state=%0d bp=%0b, required 4 0", state, ball_pause);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({state, ball_pause, ball_rst} !== {3'd0, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL rst_async: state=%0d bp=%0b brst=%0b, required 0 1 1", state, ball_pause, ball_rst);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            if (ball_pause === 1'b0) np++;
        end
        n_checks++;
        if ({np, state} !== {32'd0, 3'd0}) begin
            n_fail++;
            $display("FAIL rst_after: pulses=%0d state=%0d, required 0 0", np, state);
        end
    endtask

    initial begin
        test_reset();
        test_serve();
        test_play();
        test_miss_over();
        test_pause();
        test_rst_in_move();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
